// File: rtl/exception_unit.sv
// ============================================================================
//  Module      : exception_unit
//  Description : Commit-point exception arbiter feeding COP0; picks one cause
//                by priority, writes COP0, flushes the pipe and redirects fetch.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module exception_unit #(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cm_valid,
  input  logic        cm_stall,
  input  logic [31:0] cm_pc,
  input  logic        cm_bd,
  input  logic        cm_if_adel,
  input  logic        cm_ri,
  input  logic        cm_ov,
  input  logic        cm_syscall,
  input  logic        cm_break,
  input  logic        cm_mem_adel,
  input  logic        cm_mem_ades,
  input  logic [31:0] cm_mem_addr,
  input  logic        cm_eret,
  input  logic        cp0_allow_int,
  input  logic [7:0]  cp0_int_flag,
  input  logic [31:0] cp0_epc,
  output logic        exp_en,
  output logic        exp_badvaddr_en,
  output logic [31:0] exp_badvaddr,
  output logic        exp_bd,
  output logic [4:0]  exp_code,
  output logic [31:0] exp_epc,
  output logic        exl_clean,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  localparam int unsigned c_cnt_w = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES);
  localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(FLUSH_CYCLES - 1);

  localparam logic [4:0] c_code_int  = 5'd0;
  localparam logic [4:0] c_code_adel = 5'd4;
  localparam logic [4:0] c_code_ades = 5'd5;
  localparam logic [4:0] c_code_sys  = 5'd8;
  localparam logic [4:0] c_code_bp   = 5'd9;
  localparam logic [4:0] c_code_ri   = 5'd10;
  localparam logic [4:0] c_code_ov   = 5'd12;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  state_t             r_state;
  logic [c_cnt_w-1:0] r_flush_cnt;
  logic [4:0]         r_last_code;
  logic               r_last_bd;

  logic        w_int_req;
  logic        w_sample;
  logic        w_exc;
  logic [4:0]  w_code;
  logic        w_bven;
  logic [31:0] w_badv;
  logic [31:0] w_epc;
  logic        w_take_exc;
  logic        w_take_eret;

  assign w_int_req   = cp0_allow_int & (|cp0_int_flag);
  assign w_sample    = (r_state == ST_IDLE) & cm_valid & ~cm_stall;
  assign w_epc       = cm_bd ? (cm_pc - 32'd4) : cm_pc;
  assign w_take_exc  = w_sample & w_exc;
  assign w_take_eret = w_sample & ~w_exc & cm_eret;

  // Priority chain: the first matching cause wins; ERET only if none match.
  always_comb begin
    w_exc  = 1'b1;
    w_code = c_code_int;
    w_bven = 1'b0;
    w_badv = cm_pc;
    if (w_int_req) begin
      w_code = c_code_int;
    end else if (cm_if_adel) begin
      w_code = c_code_adel;
      w_bven = 1'b1;
      w_badv = cm_pc;
    end else if (cm_ri) begin
      w_code = c_code_ri;
    end else if (cm_ov) begin
      w_code = c_code_ov;
    end else if (cm_syscall) begin
      w_code = c_code_sys;
    end else if (cm_break) begin
      w_code = c_code_bp;
    end else if (cm_mem_adel) begin
      w_code = c_code_adel;
      w_bven = 1'b1;
      w_badv = cm_mem_addr;
    end else if (cm_mem_ades) begin
      w_code = c_code_ades;
      w_bven = 1'b1;
      w_badv = cm_mem_addr;
    end else begin
      w_exc  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= ST_IDLE;
      r_flush_cnt     <= '0;
      r_last_code     <= '0;
      r_last_bd       <= 1'b0;
      exp_en          <= 1'b0;
      exp_badvaddr_en <= 1'b0;
      exp_badvaddr    <= '0;
      exp_bd          <= 1'b0;
      exp_code        <= '0;
      exp_epc         <= '0;
      exl_clean       <= 1'b0;
      flush           <= 1'b0;
      redirect_valid  <= 1'b0;
      redirect_pc     <= '0;
    end else begin
      exp_en          <= 1'b0;
      exp_badvaddr_en <= 1'b0;
      redirect_valid  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_take_exc) begin
            exp_en          <= 1'b1;
            exp_badvaddr_en <= w_bven;
            if (w_bven) exp_badvaddr <= w_badv;
            exp_bd          <= cm_bd;
            exp_code        <= w_code;
            exp_epc         <= w_epc;
            exl_clean       <= 1'b0;
            redirect_valid  <= 1'b1;
            redirect_pc     <= EXC_VECTOR;
            r_last_code     <= w_code;
            r_last_bd       <= cm_bd;
            flush           <= 1'b1;
            r_flush_cnt     <= c_cnt_load;
            r_state         <= ST_FLUSH;
          end else if (w_take_eret) begin
            // Cause is preserved across ERET, so replay the last code/BD.
            exp_en          <= 1'b1;
            exp_bd          <= r_last_bd;
            exp_code        <= r_last_code;
            exp_epc         <= cp0_epc;
            exl_clean       <= 1'b1;
            redirect_valid  <= 1'b1;
            redirect_pc     <= cp0_epc;
            flush           <= 1'b1;
            r_flush_cnt     <= c_cnt_load;
            r_state         <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (r_flush_cnt == '0) begin
            flush   <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_flush_cnt <= r_flush_cnt - 1'b1;
          end
        end
        default: begin
          flush   <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_exception_unit.sv
// ============================================================================
//  Module      : tb_exception_unit
//  Description : Scoreboard bench for exception_unit with directed vectors.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_exception_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        cm_valid, cm_stall, cm_bd;
  logic [31:0] cm_pc, cm_mem_addr, cp0_epc;
  logic        cm_if_adel, cm_ri, cm_ov, cm_syscall, cm_break;
  logic        cm_mem_adel, cm_mem_ades, cm_eret, cp0_allow_int;
  logic [7:0]  cp0_int_flag;
  logic        exp_en, exp_badvaddr_en, exp_bd, exl_clean, flush, redirect_valid;
  logic [31:0] exp_badvaddr, exp_epc, redirect_pc;
  logic [4:0]  exp_code;

  exception_unit dut (
    .clk(clk), .rst(rst),
    .cm_valid(cm_valid), .cm_stall(cm_stall), .cm_pc(cm_pc), .cm_bd(cm_bd),
    .cm_if_adel(cm_if_adel), .cm_ri(cm_ri), .cm_ov(cm_ov),
    .cm_syscall(cm_syscall), .cm_break(cm_break),
    .cm_mem_adel(cm_mem_adel), .cm_mem_ades(cm_mem_ades),
    .cm_mem_addr(cm_mem_addr), .cm_eret(cm_eret),
    .cp0_allow_int(cp0_allow_int), .cp0_int_flag(cp0_int_flag), .cp0_epc(cp0_epc),
    .exp_en(exp_en), .exp_badvaddr_en(exp_badvaddr_en), .exp_badvaddr(exp_badvaddr),
    .exp_bd(exp_bd), .exp_code(exp_code), .exp_epc(exp_epc),
    .exl_clean(exl_clean), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  code;
    logic        bd;
    logic [31:0] epc;
    logic        bven;
    logic [31:0] badv;
    logic        exl;
    logic [31:0] rpc;
    int          due;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops one expectation per exp_en pulse and tracks flush width.
  int   run = 0;
  logic aborted = 1'b0;
  logic prev_en = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) aborted = 1'b1;
    if (flush) run++;
    else begin
      if (run != 0 && !aborted) chk("flush_len", run, 2);
      run = 0;
      aborted = rst;
    end
    chk("redirect_eq_en", {31'd0, redirect_valid}, {31'd0, exp_en});
    if (exp_en && prev_en) chk("en_pulse", 32'd1, 32'd0);
    prev_en = exp_en;
    if (exp_en) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: got exp_en=1 code=%0d expected no event (cycle %0d)",
                 exp_code, cyc);
      end else begin
        e = q.pop_front();
        chk("latency",   cyc, e.due);
        chk("code",      {27'd0, exp_code}, {27'd0, e.code});
        chk("bd",        {31'd0, exp_bd}, {31'd0, e.bd});
        chk("epc",       exp_epc, e.epc);
        chk("bven",      {31'd0, exp_badvaddr_en}, {31'd0, e.bven});
        if (e.bven) chk("badvaddr", exp_badvaddr, e.badv);
        chk("exl_clean", {31'd0, exl_clean}, {31'd0, e.exl});
        chk("redir_pc",  redirect_pc, e.rpc);
        chk("flush_on",  {31'd0, flush}, 32'd1);
      end
    end
  end

  task automatic clear_cm();
    cm_valid = 0; cm_stall = 0; cm_bd = 0; cm_pc = 0; cm_mem_addr = 0;
    cm_if_adel = 0; cm_ri = 0; cm_ov = 0; cm_syscall = 0; cm_break = 0;
    cm_mem_adel = 0; cm_mem_ades = 0; cm_eret = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Inputs must already be set up; expectation is pushed before the sample edge.
  task automatic go(input exp_t e);
    e.due = cyc + 1;
    q.push_back(e);
    @(posedge clk); #1;
    clear_cm();
  endtask

  function automatic exp_t mk(input logic [4:0] code, input logic bd, input logic [31:0] epc,
                              input logic bven, input logic [31:0] badv,
                              input logic exl, input logic [31:0] rpc);
    exp_t e;
    e.code = code; e.bd = bd; e.epc = epc; e.bven = bven; e.badv = badv;
    e.exl = exl; e.rpc = rpc; e.due = 0;
    return e;
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_flush"}, {31'd0, flush}, 32'd0);
    chk({tag, "_en"},    {31'd0, exp_en}, 32'd0);
    chk({tag, "_rv"},    {31'd0, redirect_valid}, 32'd0);
    chk({tag, "_bven"},  {31'd0, exp_badvaddr_en}, 32'd0);
    chk({tag, "_code"},  {27'd0, exp_code}, 32'd0);
    chk({tag, "_bd"},    {31'd0, exp_bd}, 32'd0);
    chk({tag, "_epc"},   exp_epc, 32'd0);
    chk({tag, "_badv"},  exp_badvaddr, 32'd0);
    chk({tag, "_exl"},   {31'd0, exl_clean}, 32'd0);
    chk({tag, "_rpc"},   redirect_pc, 32'd0);
  endtask

  localparam logic [31:0] VEC = 32'hBFC00380;

  initial begin
    rst = 1; clear_cm(); cp0_allow_int = 0; cp0_int_flag = 0; cp0_epc = 0;
    idle(2);
    chk_zero("reset");
    rst = 0;
    idle(2);

    // RI, no delay slot
    cm_valid = 1; cm_ri = 1; cm_pc = 32'hBFC00100;
    go(mk(5'd10, 0, 32'hBFC00100, 0, 0, 0, VEC));
    idle(3);

    // ERET replays the last cause and redirects to EPC
    cp0_epc = 32'h80001000;
    cm_valid = 1; cm_eret = 1; cm_pc = 32'h80000040;
    go(mk(5'd10, 0, 32'h80001000, 0, 0, 1, 32'h80001000));
    idle(3);

    // Fetch AdEL in delay slot
    cm_valid = 1; cm_if_adel = 1; cm_bd = 1; cm_pc = 32'h80000006; cm_ri = 1;
    go(mk(5'd4, 1, 32'h80000002, 1, 32'h80000006, 0, VEC));
    idle(3);

    // Interrupt beats Ov and AdES; slot offered during FLUSH must be ignored
    cp0_allow_int = 1; cp0_int_flag = 8'h04;
    cm_valid = 1; cm_ov = 1; cm_mem_ades = 1; cm_mem_addr = 32'h00001234; cm_pc = 32'h80000010;
    go(mk(5'd0, 0, 32'h80000010, 0, 0, 0, VEC));
    cm_valid = 1; cm_ri = 1; cm_pc = 32'h80000014;
    idle(2);
    clear_cm(); cp0_allow_int = 0; cp0_int_flag = 0;
    idle(2);

    // Data AdES reports the data address
    cm_valid = 1; cm_mem_ades = 1; cm_mem_addr = 32'h00000123; cm_pc = 32'h80000020;
    go(mk(5'd5, 0, 32'h80000020, 1, 32'h00000123, 0, VEC));
    idle(3);

    // Data AdEL outranks AdES
    cm_valid = 1; cm_mem_adel = 1; cm_mem_ades = 1; cm_mem_addr = 32'h00000456; cm_pc = 32'h80000030;
    go(mk(5'd4, 0, 32'h80000030, 1, 32'h00000456, 0, VEC));
    idle(3);

    // SYSCALL outranks BREAK and ERET
    cm_valid = 1; cm_syscall = 1; cm_break = 1; cm_eret = 1; cm_pc = 32'h80000050;
    go(mk(5'd8, 0, 32'h80000050, 0, 0, 0, VEC));
    idle(3);

    // Stalled RI is held until the stall drops
    cm_valid = 1; cm_stall = 1; cm_ri = 1; cm_pc = 32'h80000060;
    idle(3);
    cm_stall = 0;
    go(mk(5'd10, 0, 32'h80000060, 0, 0, 0, VEC));
    idle(3);

    // Pending interrupt with an empty slot, taken on the next valid commit
    cp0_allow_int = 1; cp0_int_flag = 8'h01;
    idle(3);
    cm_valid = 1; cm_pc = 32'h00000100;
    go(mk(5'd0, 0, 32'h00000100, 0, 0, 0, VEC));
    cp0_allow_int = 0; cp0_int_flag = 0;
    idle(3);

    // BREAK in delay slot at pc 0 wraps EPC; reset hits in the first flush cycle
    cm_valid = 1; cm_break = 1; cm_bd = 1; cm_pc = 32'h00000000;
    go(mk(5'd9, 1, 32'hFFFFFFFC, 0, 0, 0, VEC));
    rst = 1;
    idle(1);
    chk_zero("midrst");
    rst = 0;
    idle(4);

    // After reset the unit is idle and last cause is cleared
    cp0_epc = 32'h00002000;
    cm_valid = 1; cm_eret = 1; cm_pc = 32'h80000070;
    go(mk(5'd0, 0, 32'h00002000, 0, 0, 1, 32'h00002000));
    idle(4);

    begin
      int guard = 0;
      while (q.size() != 0 && guard < 20) begin idle(1); guard++; end
      chk("queue_drained", q.size(), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

`default_nettype wire
